collision_scheduler: RTL
========================

Name: collision_scheduler

Overview:
- Accumulates per-pixel object-overlap flags over each video frame.
- At the frame boundary it snapshots the accumulated flags and serialises the involved objects, one at a time, to the shared physics/collision-response unit over a req/ack handshake.
- Object numbering matches the sprite-selection encoding: 1–15 = balls, 16 = cue ball, 17 = cue stick.
- Sits between the pixel-side sprite/collision logic and the single physics resolver.

Parameters:
- NUM_OBJ, 17, number of collision flag bits (bit i ↔ object index i+1).
- TIMEOUT, 255, cycles to wait for obj_ack before abandoning a request (≥2).
- SERVICE_MASK, 17'h1FFFF, bit=1 means the object is eligible for servicing; masked bits are accumulated but never requested.

Ports:
- Clk, in, 1, system clock.
- Reset_n, in, 1, asynchronous active-low reset.
- frame_start, in, 1, single-cycle pulse at start of vertical blanking.
- coll_valid, in, 1, collision_in is meaningful this cycle (active video).
- collision_in, in, NUM_OBJ, per-pixel overlap flags.
- obj_req, out, 1, request to physics unit.
- obj_idx, out, 5, object index 1..17; 0 when idle.
- obj_ack, in, 1, physics unit accepts the current request.
- busy, out, 1, high in any state except IDLE.
- done, out, 1, one-cycle pulse when a frame's servicing completes.
- serviced_cnt, out, 5, objects acknowledged in the last completed frame.
- timeout_err, out, 1, one-cycle pulse when a request is abandoned.
- overrun, out, 1, one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset (async, Reset_n=0):
  - State IDLE; accum=0, pend=0.
  - obj_req=0, obj_idx=0, done=0, timeout_err=0, overrun=0, serviced_cnt=0, timer=0.
  - A mid-handshake reset drops obj_req immediately; the pending work is lost.
- Accumulation:
  - accum <= accum | collision_in every cycle coll_valid=1, in all states.
  - Exception: on the snapshot edge (IDLE & frame_start), pend <= accum | (coll_valid ? collision_in : 0) and accum <= 0. No flag is lost or double-counted.
- State machine: IDLE, CHECK, ARB, REQ, DONE.
  - IDLE: on frame_start, snapshot, clear the working count, go to CHECK.
  - CHECK: pend <= pend & SERVICE_MASK. Compute a 5-bit popcount of the raw snapshot. If popcount < 2 (no real overlap), go to DONE; else if masked pend == 0, go to DONE; else go to ARB.
  - ARB: select the lowest set bit b of pend (fixed priority, ball 1 highest, stick lowest). Then:
    - obj_idx <= b+1, obj_req <= 1.
    - Clear bit b in pend; timer <= 0.
    - Go to REQ.
  - REQ: hold obj_req and obj_idx stable.
    - If obj_ack=1: obj_req <= 0, obj_idx <= 0, working count +1. Go to ARB if pend≠0, else DONE.
    - Else if timer == TIMEOUT-1: obj_req <= 0, obj_idx <= 0, timeout_err pulse. Next state as for ack, but no count increment.
    - Else timer <= timer+1.
  - DONE: done=1 for this cycle; serviced_cnt <= working count. Return to IDLE.
- Handshake:
  - obj_ack is sampled only while obj_req=1; acks in any other cycle are ignored.
  - obj_req never re-asserts in the cycle after it drops; ARB always intervenes, so there is one idle cycle between requests.
- Latency:
  - frame_start in cycle 0 → CHECK in cycle 1 → ARB in cycle 2 → obj_req high in cycle 3.
  - An ack in cycle k → obj_req low in cycle k+1; the next request rises in cycle k+2.
- Overrun:
  - frame_start while busy: overrun pulse. No snapshot; accum is not cleared and keeps accumulating.
  - The current servicing continues undisturbed. Flags appear in the next accepted snapshot.
- Boundaries:
  - frame_start coincident with the DONE cycle counts as busy → overrun.
  - All 17 bits set with SERVICE_MASK default → 17 requests; serviced_cnt=17 fits in 5 bits.
  - Counter widths: timer ≥ ceil(log2(TIMEOUT)) bits; serviced_cnt saturates at 31; it is never reached with NUM_OBJ=17.

Test Plan:
- Reset mid-REQ with obj_req=1 → obj_req, obj_idx, busy drop asynchronously to 0; after release, frame_start with empty accum → done pulse at cycle 2, serviced_cnt=0, no obj_req.
- Accumulate collision_in=17'h00005 then 17'h08000 during video; frame_start → requests obj_idx=1, 3, 16 in that order; ack each after 2 cycles → done, serviced_cnt=3.
- Snapshot with only 17'h00010 (popcount 1) → no request, done pulse, serviced_cnt=0.
- Bits 0 and 16 set, SERVICE_MASK=17'h0FFFF → only obj_idx=1 requested; serviced_cnt=1.
- Two objects, never ack, TIMEOUT=4 → each obj_req held exactly 4 cycles, two timeout_err pulses, serviced_cnt=0.
- frame_start while in REQ, plus collision_in=17'h00003 with coll_valid in the same cycle → overrun pulse, current request continues; next frame_start services 1 and 2.

Source files
------------

// File: rtl/collision_scheduler_if.sv
// Request/acknowledge channel between the collision scheduler
// and the shared physics resolver.
interface collision_scheduler_if;
  logic       obj_req;
  logic [4:0] obj_idx;
  logic       obj_ack;

  modport master (
    output obj_req,
    output obj_idx,
    input  obj_ack
  );

  modport slave (
    input  obj_req,
    input  obj_idx,
    output obj_ack
  );
endinterface

// File: rtl/collision_scheduler.sv
// Per-frame collision flag accumulator that serialises involved
// objects to the physics resolver, lowest index first.
module collision_scheduler #(
  parameter int                 NUM_OBJ      = 17,
  parameter int                 TIMEOUT      = 255,
  parameter logic [NUM_OBJ-1:0] SERVICE_MASK = 17'h1FFFF
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  frame_start,
  input  logic                  coll_valid,
  input  logic [NUM_OBJ-1:0]    collision_in,
  collision_scheduler_if.master phys,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            serviced_cnt,
  output logic                  timeout_err,
  output logic                  overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [NUM_OBJ-1:0] ONE = NUM_OBJ'(1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ARB,
    REQ,
    DONE
  } state_t;

  state_t             state;
  logic [NUM_OBJ-1:0] accum;
  logic [NUM_OBJ-1:0] pend;
  logic [NUM_OBJ-1:0] coll_v;
  logic [NUM_OBJ-1:0] masked;
  logic [TW-1:0]      timer;
  logic [4:0]         work_cnt;
  logic [4:0]         cnt_inc;
  logic [4:0]         pop;
  logic [4:0]         low_idx;
  logic               more;

  assign coll_v  = coll_valid ? collision_in : '0;
  assign masked  = pend & SERVICE_MASK;
  assign busy    = (state != IDLE);
  assign more    = (pend != '0);
  assign cnt_inc = (work_cnt == 5'd31) ? work_cnt
                                       : work_cnt + 5'd1;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_OBJ; i++)
      pop = pop + 5'(pend[i]);
  end

  // Scan downwards so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--)
      if (pend[i])
        low_idx = 5'(i + 1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      accum        <= '0;
      pend         <= '0;
      timer        <= '0;
      work_cnt     <= '0;
      phys.obj_req <= 1'b0;
      phys.obj_idx <= '0;
      done         <= 1'b0;
      serviced_cnt <= '0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= frame_start && (state != IDLE);

      if (state == IDLE && frame_start)
        accum <= '0;
      else
        accum <= accum | coll_v;

      unique case (state)
        IDLE: begin
          if (frame_start) begin
            pend     <= accum | coll_v;
            work_cnt <= '0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          pend <= masked;
          if (pop < 5'd2 || masked == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ARB;
          end
        end
        ARB: begin
          phys.obj_idx <= low_idx;
          phys.obj_req <= 1'b1;
          pend         <= pend & (pend - ONE);
          timer        <= '0;
          state        <= REQ;
        end
        REQ: begin
          if (phys.obj_ack || timer == T_LAST) begin
            phys.obj_req <= 1'b0;
            phys.obj_idx <= '0;
            if (phys.obj_ack)
              work_cnt <= cnt_inc;
            else
              timeout_err <= 1'b1;
            if (more) begin
              state <= ARB;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          serviced_cnt <= work_cnt;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
